// File: rtl/cpu_mem_pkg.sv
// Shared definitions for the unified instruction/data memory port.
// Holds the default bus widths and the encoding of the read-owner tag that
// steers returning read data back to fetch or load/store.
package cpu_mem_pkg;

    localparam int ADDR_W_DEF = 16;
    localparam int DATA_W_DEF = 16;

    typedef enum logic [1:0] {
        TAG_NONE = 2'd0,
        TAG_IF   = 2'd1,
        TAG_LS   = 2'd2
    } owner_tag_e;

endpackage

// File: rtl/mem_starve_ctr.sv
// Saturating starvation counter for the fetch requester.
// Ports:
//   clk, rst   : clock, asynchronous active-high reset
//   inc        : fetch was denied this cycle
//   clr        : fetch was granted or not requesting this cycle (wins over inc)
//   cnt        : current count, saturates at STARVE_MAX
module mem_starve_ctr #(
    parameter int unsigned STARVE_MAX = 3
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       inc,
    input  logic       clr,
    output logic [3:0] cnt
);

    logic [3:0] cnt_q;
    logic [3:0] cnt_d;

    always_comb begin
        cnt_d = cnt_q;
        if (clr) begin
            cnt_d = 4'd0;
        end else if (inc && (cnt_q < 4'(STARVE_MAX))) begin
            cnt_d = cnt_q + 4'd1;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt_q <= 4'd0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign cnt = cnt_q;

endmodule

// File: rtl/mem_port_arbiter.sv
// Arbiter for the single-ported unified memory shared by instruction fetch
// and the load/store unit. Grants one requester per cycle (load/store first,
// with a starvation escape for fetch), drives the memory port, and tags each
// read so the data returning one cycle later reaches the right requester.
// A flush squashes the fetch read returning in the same cycle.
//
// Ports:
//   clk, rst                       : clock, asynchronous active-high reset
//   if_req/if_addr                 : fetch read request
//   if_grant/fetch_stall           : combinational fetch accept / stall
//   if_rvalid/if_rdata             : fetch read return
//   flush                          : kill the fetch read returning this cycle
//   ls_req/ls_we/ls_addr/ls_wdata  : load/store request
//   ls_grant                       : combinational load/store accept
//   ls_rvalid/ls_rdata             : load read return
//   mem_addr/mem_we/mem_wdata      : memory command
//   mem_rdata                      : memory read data (one cycle latency)
//
// Owner tag states:
//   state    | meaning
//   TAG_NONE | no read returns this cycle
//   TAG_IF   | data on mem_rdata belongs to fetch
//   TAG_LS   | data on mem_rdata belongs to a load
module mem_port_arbiter
    import cpu_mem_pkg::*;
#(
    parameter int unsigned ADDR_W     = ADDR_W_DEF,
    parameter int unsigned DATA_W     = DATA_W_DEF,
    parameter int unsigned STARVE_MAX = 3
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              if_req,
    input  logic [ADDR_W-1:0] if_addr,
    output logic              if_grant,
    output logic              if_rvalid,
    output logic [DATA_W-1:0] if_rdata,
    output logic              fetch_stall,
    input  logic              flush,
    input  logic              ls_req,
    input  logic              ls_we,
    input  logic [ADDR_W-1:0] ls_addr,
    input  logic [DATA_W-1:0] ls_wdata,
    output logic              ls_grant,
    output logic              ls_rvalid,
    output logic [DATA_W-1:0] ls_rdata,
    output logic [ADDR_W-1:0] mem_addr,
    output logic              mem_we,
    output logic [DATA_W-1:0] mem_wdata,
    input  logic [DATA_W-1:0] mem_rdata
);

    owner_tag_e tag_q;
    owner_tag_e tag_d;
    logic [3:0] starve_cnt;
    logic       starve_sat;

    mem_starve_ctr #(
        .STARVE_MAX (STARVE_MAX)
    ) u_starve_ctr (
        .clk (clk),
        .rst (rst),
        .inc (if_req & ~if_grant),
        .clr (~if_req | if_grant),
        .cnt (starve_cnt)
    );

    assign starve_sat = (starve_cnt >= 4'(STARVE_MAX));

    always_comb begin
        if_grant  = 1'b0;
        ls_grant  = 1'b0;
        mem_addr  = if_addr;
        mem_we    = 1'b0;
        mem_wdata = '0;
        tag_d     = TAG_NONE;

        // Load/store wins unless fetch has been denied STARVE_MAX cycles in a row.
        if (ls_req && !starve_sat) begin
            ls_grant = 1'b1;
        end else if (if_req) begin
            if_grant = 1'b1;
        end else if (ls_req) begin
            ls_grant = 1'b1;
        end

        if (ls_grant) begin
            mem_addr  = ls_addr;
            mem_we    = ls_we;
            mem_wdata = ls_wdata;
        end

        // Stores return nothing, so they leave no tag behind.
        if (if_grant) begin
            tag_d = TAG_IF;
        end else if (ls_grant && !ls_we) begin
            tag_d = TAG_LS;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            tag_q <= TAG_NONE;
        end else begin
            tag_q <= tag_d;
        end
    end

    assign fetch_stall = if_req & ~if_grant;

    // Flush acts on the returning fetch data combinationally; the fetch
    // request issued in the same cycle is unaffected.
    assign if_rvalid = (tag_q == TAG_IF) && !flush;
    assign ls_rvalid = (tag_q == TAG_LS);
    assign if_rdata  = if_rvalid ? mem_rdata : '0;
    assign ls_rdata  = ls_rvalid ? mem_rdata : '0;

endmodule

// File: tb/tb_mem_port_arbiter.sv
module tb_mem_port_arbiter;

    localparam int AW   = 16;
    localparam int DW   = 16;
    localparam int SMAX = 3;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          if_req = 1'b0;
    logic [AW-1:0] if_addr = '0;
    logic          if_grant, if_rvalid, fetch_stall;
    logic [DW-1:0] if_rdata;
    logic          flush = 1'b0;
    logic          ls_req = 1'b0;
    logic          ls_we = 1'b0;
    logic [AW-1:0] ls_addr = '0;
    logic [DW-1:0] ls_wdata = '0;
    logic          ls_grant, ls_rvalid;
    logic [DW-1:0] ls_rdata;
    logic [AW-1:0] mem_addr;
    logic          mem_we;
    logic [DW-1:0] mem_wdata;
    logic [DW-1:0] mem_rdata = '0;

    int tests_run = 0;
    int tests_failed = 0;

    // memory attached to the port, and the model's own shadow copy
    logic [DW-1:0] mem [0:65535];
    logic [DW-1:0] ref_mem [0:65535];

    // reference model state
    int            m_starve = 0;
    int            m_pend   = 0;   // 0 nothing, 1 fetch read, 2 load read
    logic [DW-1:0] m_pdata  = '0;

    always #5 clk = ~clk;

    mem_port_arbiter #(.ADDR_W(AW), .DATA_W(DW), .STARVE_MAX(SMAX)) dut (
        .clk         (clk),
        .rst         (rst),
        .if_req      (if_req),
        .if_addr     (if_addr),
        .if_grant    (if_grant),
        .if_rvalid   (if_rvalid),
        .if_rdata    (if_rdata),
        .fetch_stall (fetch_stall),
        .flush       (flush),
        .ls_req      (ls_req),
        .ls_we       (ls_we),
        .ls_addr     (ls_addr),
        .ls_wdata    (ls_wdata),
        .ls_grant    (ls_grant),
        .ls_rvalid   (ls_rvalid),
        .ls_rdata    (ls_rdata),
        .mem_addr    (mem_addr),
        .mem_we      (mem_we),
        .mem_wdata   (mem_wdata),
        .mem_rdata   (mem_rdata)
    );

    always @(posedge clk) begin
        if (mem_we) mem[mem_addr] <= mem_wdata;
        mem_rdata <= mem[mem_addr];
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests_run++;
        if (obs !== exp) begin
            tests_failed++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, obs, exp, $time);
        end
    endtask

    // One cycle: drive inputs after the falling edge, compare against the
    // model, then advance the model as the rising edge will advance the DUT.
    task automatic step(input logic ireq, input logic [AW-1:0] iaddr,
                        input logic lreq, input logic lwe, input logic [AW-1:0] laddr,
                        input logic [DW-1:0] lwdata, input logic fl);
        logic e_ig, e_lg;
        @(negedge clk);
        if_req = ireq; if_addr = iaddr; ls_req = lreq; ls_we = lwe;
        ls_addr = laddr; ls_wdata = lwdata; flush = fl;
        #1;
        e_lg = lreq && (m_starve < SMAX);
        e_ig = ireq && !e_lg;
        if (!e_ig && !e_lg && lreq) e_lg = 1'b1;
        check("if_grant", 32'(if_grant), 32'(e_ig));
        check("ls_grant", 32'(ls_grant), 32'(e_lg));
        check("fetch_stall", 32'(fetch_stall), 32'(ireq && !e_ig));
        check("mem_we", 32'(mem_we), 32'(e_lg && lwe));
        check("mem_addr", 32'(mem_addr), 32'(e_lg ? laddr : iaddr));
        if (!e_ig) check("mem_wdata", 32'(mem_wdata), 32'(e_lg ? lwdata : '0));
        check("if_rvalid", 32'(if_rvalid), 32'(m_pend == 1 && !fl));
        check("if_rdata", 32'(if_rdata), (m_pend == 1 && !fl) ? 32'(m_pdata) : 32'd0);
        check("ls_rvalid", 32'(ls_rvalid), 32'(m_pend == 2));
        check("ls_rdata", 32'(ls_rdata), (m_pend == 2) ? 32'(m_pdata) : 32'd0);
        if (ireq && !e_ig) m_starve = (m_starve + 1 > SMAX) ? SMAX : m_starve + 1;
        else               m_starve = 0;
        m_pend = 0;
        if (e_ig) begin
            m_pend = 1; m_pdata = ref_mem[iaddr];
        end else if (e_lg && !lwe) begin
            m_pend = 2; m_pdata = ref_mem[laddr];
        end else if (e_lg && lwe) begin
            ref_mem[laddr] = lwdata;
        end
    endtask

    task automatic idle_inputs();
        if_req = 1'b0; ls_req = 1'b0; ls_we = 1'b0; flush = 1'b0;
    endtask

    initial begin
        for (int i = 0; i < 65536; i++) begin
            mem[i]     = 16'(16'h1000 + i);
            ref_mem[i] = 16'(16'h1000 + i);
        end
        mem[16'h0040]     = 16'hBEEF;
        ref_mem[16'h0040] = 16'hBEEF;

        // reset state
        #2;
        check("rst if_rvalid", 32'(if_rvalid), 32'd0);
        check("rst ls_rvalid", 32'(ls_rvalid), 32'd0);
        check("rst ls_rdata", 32'(ls_rdata), 32'd0);
        @(posedge clk); #2 rst = 1'b0;

        // fetch stream
        step(1, 16'h0000, 0, 0, 16'h0, 16'h0, 0);
        step(1, 16'h0001, 0, 0, 16'h0, 16'h0, 0);
        step(1, 16'h0002, 0, 0, 16'h0, 16'h0, 0);
        step(0, 16'h0000, 0, 0, 16'h0, 16'h0, 0);

        // load beats concurrent fetch
        step(1, 16'h0005, 1, 0, 16'h0040, 16'h0, 0);
        step(0, 16'h0000, 0, 0, 16'h0, 16'h0, 0);

        // starvation escape: ls ls ls if ls ls
        for (int i = 0; i < 6; i++) step(1, 16'(16'h0100 + i), 1, 0, 16'(16'h0200 + i), 16'h0, 0);
        step(0, 16'h0000, 0, 0, 16'h0, 16'h0, 0);

        // flush kills returning fetch, branch-target fetch proceeds
        step(1, 16'h0010, 0, 0, 16'h0, 16'h0, 0);
        step(1, 16'h0080, 0, 0, 16'h0, 16'h0, 1);
        step(0, 16'h0000, 0, 0, 16'h0, 16'h0, 0);

        // store then load of the same address
        step(0, 16'h0000, 1, 1, 16'h0020, 16'h1234, 0);
        step(0, 16'h0000, 1, 0, 16'h0020, 16'h0, 0);
        step(0, 16'h0000, 0, 0, 16'h0, 16'h0, 0);

        // async reset right after a load grant, with the counter nonzero
        step(1, 16'h0003, 1, 0, 16'h0041, 16'h0, 0);
        step(1, 16'h0003, 1, 0, 16'h0040, 16'h0, 0);
        @(posedge clk); #2;
        rst = 1'b1;
        idle_inputs();
        #1;
        check("rst ls_rvalid mid", 32'(ls_rvalid), 32'd0);
        check("rst ls_rdata mid", 32'(ls_rdata), 32'd0);
        check("rst if_rvalid mid", 32'(if_rvalid), 32'd0);
        m_starve = 0; m_pend = 0;
        @(posedge clk); #2 rst = 1'b0;
        for (int i = 0; i < 5; i++) step(1, 16'(16'h0300 + i), 1, 0, 16'(16'h0040 + i), 16'h0, 0);
        step(0, 16'h0000, 0, 0, 16'h0, 16'h0, 0);

        // randomized traffic over a small address window
        for (int i = 0; i < 400; i++) begin
            step(1'($urandom_range(0, 3) != 0),
                 16'($urandom_range(0, 63)),
                 1'($urandom_range(0, 2) != 0),
                 1'($urandom_range(0, 3) == 0),
                 16'($urandom_range(0, 63)),
                 16'($urandom),
                 1'($urandom_range(0, 4) == 0));
        end
        step(0, 16'h0000, 0, 0, 16'h0, 16'h0, 0);

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule

// File: doc/mem_port_arbiter.md
Name: mem_port_arbiter

Overview:
Shares the single-ported, unified 16-bit instruction/data memory between the instruction-fetch stage and the load/store unit. The block grants one requester per cycle, drives the memory port, and tags each in-flight read so that returning data reaches the correct requester. It also generates the fetch stall, and it drops instruction reads that a pipeline flush has made stale. Load/store has priority, and a starvation counter guarantees fetch progress.

Parameters:
ADDR_W, 16, memory address width
DATA_W, 16, memory word width
STARVE_MAX, 3, consecutive denied fetch-request cycles after which fetch wins one cycle (range 1..15)

Ports:
clk  in  1  system clock, rising edge
rst  in  1  asynchronous, active-high reset
if_req  in  1  fetch requests a read this cycle
if_addr  in  ADDR_W  fetch read address
if_grant  out  1  fetch request accepted this cycle (combinational)
if_rvalid  out  1  fetch read data valid (registered, one cycle after grant)
if_rdata  out  DATA_W  fetch read data
fetch_stall  out  1  if_req & ~if_grant (combinational)
flush  in  1  pipeline flush; kills the fetch read returning this cycle
ls_req  in  1  load/store requests access
ls_we  in  1  1 = write, 0 = read
ls_addr  in  ADDR_W  load/store address
ls_wdata  in  DATA_W  store data
ls_grant  out  1  load/store request accepted this cycle (combinational)
ls_rvalid  out  1  load data valid (one cycle after a read grant)
ls_rdata  out  DATA_W  load data
mem_addr  out  ADDR_W  memory address
mem_we  out  1  memory write enable
mem_wdata  out  DATA_W  memory write data
mem_rdata  in  DATA_W  memory read data, valid one cycle after the address is presented

Behaviour:
- Arbitration (combinational, every cycle):
  - ls_req=1 and starve_cnt<STARVE_MAX: ls_grant=1.
  - Else if_req=1: if_grant=1.
  - Else ls_req=1: ls_grant=1.
  - if_grant and ls_grant are never both 1.
- Memory drive:
  - When ls_grant=1: mem_addr=ls_addr, mem_we=ls_we, mem_wdata=ls_wdata.
  - When if_grant=1: mem_addr=if_addr, mem_we=0.
  - When no grant: mem_addr=if_addr, mem_we=0, mem_wdata=0.
- starve_cnt (4-bit register):
  - Increments when if_req=1 and if_grant=0, saturating at STARVE_MAX.
  - Clears to 0 on any cycle with if_grant=1, or with if_req=0.
- Owner tag FSM (registered, states NONE / IF / LS):
  - Next state is IF on if_grant.
  - Next state is LS on ls_grant with ls_we=0.
  - Otherwise next state is NONE; writes produce no tag.
  - Tag IF: if_rvalid=~flush, if_rdata=mem_rdata.
  - Tag LS: ls_rvalid=1, ls_rdata=mem_rdata.
  - Tag NONE: both rvalid=0.
  - Each rdata reads 0 whenever its rvalid=0.
- Latency: a read granted in cycle N returns in cycle N+1. Back-to-back grants are allowed every cycle; throughput is 1 access/cycle.
- Flush:
  - Affects only the fetch read returning in the same cycle.
  - A fetch grant issued in the flush cycle (branch target) proceeds normally and returns in the next cycle.
  - Flush never affects load/store.
- Stall: fetch_stall follows the combinational rule and is independent of flush.
- Reset (async): starve_cnt=0, tag=NONE.
  - Registered outputs go to 0 immediately: if_rvalid, ls_rvalid, if_rdata, ls_rdata.
  - A read in flight when rst asserts is discarded; no rvalid follows deassertion.
  - Grants remain combinational during reset, but no state advances.
- Simultaneous events:
  - Both requesting with starve_cnt==STARVE_MAX: fetch wins and the counter clears.
  - A write followed by a read of the same address returns the memory's post-write data; no forwarding occurs in this block.

Decomposition:
- Shared package cpu_mem_pkg:
  - owner tag encoding: TAG_NONE=2'd0, TAG_IF=2'd1, TAG_LS=2'd2
  - ADDR_W/DATA_W defaults
- Optional sub-module mem_starve_ctr (saturating starvation counter with clear).
- Everything else stays flat in mem_port_arbiter.

Test Plan:
- Fetch only, if_req=1, addrs 0x0000,0x0001,0x0002 on consecutive cycles, memory preloaded mem[i]=0x1000+i -> if_grant=1 each cycle, if_rvalid with 0x1000,0x1001,0x1002 one cycle later, fetch_stall=0 throughout.
- Load at 0x0040 (mem=0xBEEF) concurrent with fetch at 0x0005 -> ls_grant=1, fetch_stall=1 in that cycle, ls_rvalid/ls_rdata=0xBEEF next cycle, if_rvalid=0.
- ls_req held high for 6 cycles with if_req high, STARVE_MAX=3 -> ls_grant in cycles 0-2, if_grant in cycle 3, ls_grant in cycles 4-5, starve_cnt 0,1,2,3,0,1.
- Fetch read of 0x0010 granted in cycle N, flush=1 in N+1 with if_addr=0x0080 -> if_rvalid=0 in N+1, if_grant=1 in N+1, if_rvalid=1 with mem[0x0080] in N+2.
- Store 0x1234 to 0x0020, then load 0x0020 -> mem_we=1 for one cycle, no rvalid for the store, ls_rdata=0x1234 after the load.
- rst pulsed asynchronously mid-cycle right after a load grant -> ls_rvalid stays 0, starve_cnt=0, tag=NONE, normal grants resume the cycle after deassertion.
